// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO and launch sequencer in front of a single-byte I2C master.
// Optional per-phase watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [6:0]               cmd_addr,
    input  logic [7:0]               cmd_wdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [6:0]               m_addr,
    output logic [7:0]               m_data_in,
    output logic                     m_rw,
    output logic                     m_enable,
    input  logic                     m_ready,
    input  logic [7:0]               m_data_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic          sync1;
    logic          ready_s;
    logic          push;
    logic          pop;
    logic          launch_done;
    logic          done;
    logic          abort;

    assign cmd_ready   = (level != LW'(DEPTH));
    assign fifo_level  = level;
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == IDLE) && (level != '0) && ready_s;
    assign launch_done = (state == LAUNCH) && !ready_s;
    assign done        = (state == WAIT_DONE) && ready_s;
    assign rsp_valid   = (state == RESP);
    assign busy        = (state != IDLE) || (level != '0);

    // m_ready comes from the master's slow clock domain; idle level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            ready_s <= 1'b1;
        end else begin
            sync1   <= m_ready;
            ready_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt;
    logic          in_phase;

    assign in_phase = (state == LAUNCH) || (state == WAIT_DONE);
    // A normal phase exit on the same cycle as the deadline takes priority
    assign abort    = in_phase && !launch_done && !done &&
                      (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     to_cnt <= '0;
        else if (pop || launch_done) to_cnt <= '0;
        else if (in_phase)           to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rsp_err <= 1'b0;
        else if (done)  rsp_err <= 1'b0;
        else if (abort) rsp_err <= 1'b1;
    end
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m_enable  <= 1'b0;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {m_rw, m_addr, m_data_in} <= mem[rd_ptr];
                        m_enable <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (launch_done) begin
                        m_enable <= 1'b0;
                        state    <= WAIT_DONE;
                    end else if (abort) begin
                        m_enable  <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        rsp_rdata <= m_rw ? m_data_out : 8'h00;
                        state     <= RESP;
                    end else if (abort) begin
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: behavioural I2C master/slave model,
// command/response scoreboard queues, directed and randomized command streams.
module tb_i2c_cmd_sequencer;
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [2:0] fifo_level;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic       m_ready;
    logic [7:0] m_data_out;

    int   checks = 0;
    int   errors = 0;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    logic [7:0] slave_mem [128];

    bit   stall = 0;
    bit   dead = 0;
    bit   long_mode = 0;
    bit   mst_busy = 0;
    int   mst_cnt;
    int   mst_dur;
    logic cur_rw;
    logic [6:0] cur_addr;
    logic prev_valid = 1'b0;

    i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .fifo_level(fifo_level),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
        .m_ready(m_ready), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master model: accepts on enable while ready, requires enable low before finishing
    initial begin
        m_ready = 1'b1;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ready = 1'b1;
                mst_busy = 0;
            end else if (mst_busy) begin
                mst_cnt++;
                if (mst_cnt >= mst_dur) begin
                    check("stop_enable_low", 16'(m_enable), 16'd0);
                    m_data_out = cur_rw ? slave_mem[cur_addr] : 8'($urandom);
                    m_ready = 1'b1;
                    mst_busy = 0;
                end
            end else if (stall) begin
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
                if (m_enable === 1'b1 && !dead) begin
                    check("acc_pending", 16'(cmd_q.size() != 0), 16'd1);
                    if (cmd_q.size() != 0) begin
                        cmd_t c;
                        c = cmd_q.pop_front();
                        check("acc_addr", 16'(m_addr), 16'(c.addr));
                        check("acc_rw", 16'(m_rw), 16'(c.rw));
                        check("acc_wdata", 16'(m_data_in), 16'(c.wdata));
                    end
                    cur_rw = m_rw;
                    cur_addr = m_addr;
                    m_ready = 1'b0;
                    mst_busy = 1;
                    mst_cnt = 0;
                    mst_dur = long_mode ? 40 : int'($urandom_range(4, 10));
                end
            end
        end
    end

    // Response monitor against the in-order scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid === 1'b1) begin
                    check("rsp_one_cycle", 16'(prev_valid), 16'd0);
                    check("rsp_pending", 16'(rsp_q.size() != 0), 16'd1);
                    if (rsp_q.size() != 0) begin
                        rsp_t e;
                        e = rsp_q.pop_front();
                        check("rsp_rdata", 16'(rsp_rdata), 16'(e.rdata));
                        check("rsp_err", 16'(rsp_err), 16'(e.err));
                    end
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d, input bit tmo);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_wdata = d;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_accepted", 16'(n < 500), 16'd1);
        if (tmo) begin
            rsp_q.push_back('{8'h00, 1'b1});
        end else begin
            cmd_q.push_back('{rw, a, d});
            rsp_q.push_back('{(rw ? slave_mem[a] : 8'h00), 1'b0});
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(busy === 1'b0 && !mst_busy && rsp_q.size() == 0 && cmd_q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 16'(n < 3000), 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [6:0] a;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_rw = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        for (int i = 0; i < 128; i++) slave_mem[i] = 8'($urandom);
        slave_mem[7'h68] = 8'h3C;

        repeat (3) @(negedge clk);
        check("rst_m_enable", 16'(m_enable), 16'd0);
        check("rst_m_addr", 16'(m_addr), 16'd0);
        check("rst_m_data_in", 16'(m_data_in), 16'd0);
        check("rst_m_rw", 16'(m_rw), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_rsp_rdata", 16'(rsp_rdata), 16'd0);
        check("rst_rsp_err", 16'(rsp_err), 16'd0);
        check("rst_level", 16'(fifo_level), 16'd0);
        check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single write, then single read with known slave byte
        push(1'b0, 7'h48, 8'hA5, 0);
        idle();
        drain();
        check("write_rdata_held", 16'(rsp_rdata), 16'h00);
        push(1'b1, 7'h68, 8'h00, 0);
        idle();
        drain();
        check("read_rdata_held", 16'(rsp_rdata), 16'h3C);

        // Fill the FIFO with the master stalled; fifth command must wait
        stall = 1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) push(1'($urandom), 7'($urandom), 8'($urandom), 0);
        @(negedge clk);
        cmd_rw = 1'b1;
        cmd_addr = 7'($urandom);
        cmd_wdata = 8'($urandom);
        check("full_level", 16'(fifo_level), 16'd4);
        check("full_cmd_ready", 16'(cmd_ready), 16'd0);
        check("full_busy", 16'(busy), 16'd1);
        repeat (3) begin
            @(negedge clk);
            check("full_level_hold", 16'(fifo_level), 16'd4);
        end
        stall = 0;
        push(cmd_rw, cmd_addr, cmd_wdata, 0);
        idle();
        drain();

        // Push and pop on the same edge at level 1
        stall = 1;
        repeat (4) @(negedge clk);
        push(1'b0, 7'h11, 8'h22, 0);
        idle();
        check("pp_level_before", 16'(fifo_level), 16'd1);
        @(posedge clk);
        #1 stall = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw = 1'b1;
        cmd_addr = 7'h33;
        cmd_wdata = 8'h44;
        check("pp_ready", 16'(cmd_ready), 16'd1);
        check("pp_enable_before", 16'(m_enable), 16'd0);
        cmd_q.push_back('{1'b1, 7'h33, 8'h44});
        rsp_q.push_back('{slave_mem[7'h33], 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pp_level_after", 16'(fifo_level), 16'd1);
        check("pp_enable_after", 16'(m_enable), 16'd1);
        drain();

        // Randomized stream well past pointer wrap
        for (int i = 0; i < 20; i++) begin
            int gap;
            push(1'($urandom), 7'($urandom), 8'($urandom), 0);
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                idle();
                repeat (gap - 1) @(negedge clk);
            end
        end
        idle();
        drain();

        // Reset while waiting for completion with three entries queued
        long_mode = 1;
        for (int i = 0; i < 4; i++) push(1'($urandom), 7'($urandom), 8'($urandom), 0);
        idle();
        cnt = 0;
        while (!mst_busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("mrst_master_started", 16'(cnt < 50), 16'd1);
        repeat (6) @(negedge clk);
        check("mrst_enable_wait", 16'(m_enable), 16'd0);
        check("mrst_level_before", 16'(fifo_level), 16'd3);
        #2 rst = 1'b1;
        #1;
        check("mrst_enable", 16'(m_enable), 16'd0);
        check("mrst_level", 16'(fifo_level), 16'd0);
        check("mrst_cmd_ready", 16'(cmd_ready), 16'd1);
        check("mrst_busy", 16'(busy), 16'd0);
        cmd_q.delete();
        rsp_q.delete();
        long_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        a = 7'($urandom);
        push(1'b1, a, 8'h00, 0);
        idle();
        drain();
        check("mrst_fresh_rdata", 16'(rsp_rdata), 16'(slave_mem[a]));

`ifdef I2C_SEQ_TIMEOUT_EN
        // Dead master: ready stays high, launch phase must expire
        dead = 1;
        push(1'b1, 7'h55, 8'h66, 1);
        idle();
        cnt = 0;
        for (int i = 0; i < 1000 && rsp_valid !== 1'b1; i++) begin
            if (m_enable === 1'b1) cnt++;
            @(negedge clk);
        end
        check("tmo_enable_cycles", 16'(cnt), 16'd100);
        check("tmo_rsp_valid", 16'(rsp_valid), 16'd1);
        dead = 0;
        drain();
        check("tmo_err_held", 16'(rsp_err), 16'd1);
        push(1'b1, 7'h68, 8'h00, 0);
        idle();
        drain();
        check("tmo_next_err", 16'(rsp_err), 16'd0);
        check("tmo_next_rdata", 16'(rsp_rdata), 16'h3C);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
